// File: rtl/fine_time_pid_multi_if.sv
// Time-marker input, Hit/Match results and local-bus signals of the fine-time PID block.
interface fine_time_pid_multi_if #(
  parameter int SLICES = 32,
  parameter int NCLASS = 3
);
  logic [SLICES-1:0] TimeIn;
  logic              TimeVld;
  logic [SLICES-1:0] Hit;
  logic [NCLASS-1:0] Match;
  logic [31:0]       DataOut;
  logic [31:0]       DataIn;
  logic [7:0]        Address;
  logic              Read;
  logic              Write;

  modport slave (
    input  TimeIn, TimeVld, DataIn, Address, Read, Write,
    output Hit, Match, DataOut
  );

  modport master (
    output TimeIn, TimeVld, DataIn, Address, Read, Write,
    input  Hit, Match, DataOut
  );
endinterface

// File: rtl/fine_time_pid_multi.sv
// Leading-edge finder, per-class window match and saturating hit counters; Hit 2 clk, Match 3 clk after TimeIn.
// No backpressure: a new sample may be accepted on every clock.
module fine_time_pid_multi #(
  parameter int                   SLICES   = 32,
  parameter int                   NCLASS   = 3,
  parameter int                   RUN      = 3,
  parameter logic [7:0]           BASE     = 8'h00,
  parameter logic [32*NCLASS-1:0] WIN_INIT = '0
) (
  input logic                  clk,
  input logic                  rst,
  fine_time_pid_multi_if.slave bus
);
  // Windows live on a 32-bit bus, so only the low 32 slices are comparable.
  localparam int WB   = (SLICES < 32) ? SLICES : 32;
  localparam int LAST = SLICES - RUN - 2;

  typedef struct packed {
    logic       first_hit;
    logic [7:0] en;
  } cfg_t;

  cfg_t              cfg_q;
  logic [WB-1:0]     win_q [NCLASS];
  logic [15:0]       cnt_q [NCLASS];
  logic [SLICES-1:0] p_q;
  logic              v1_q;
  logic [SLICES-1:0] dec;
  logic [SLICES-1:0] hit_d, hit_q;
  logic [NCLASS-1:0] match_d, match_q;
  logic [31:0]       rd_dat;
  logic [7:0]        off;
  logic              clr;
  logic              unused_p0;

  assign off       = bus.Address - BASE;
  assign clr       = bus.Write && (off == 8'd0) && bus.DataIn[8];
  assign unused_p0 = p_q[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      p_q  <= bus.TimeIn;
      v1_q <= bus.TimeVld;
    end
  end

  always_comb begin
    dec = '0;
    for (int k = 0; k <= LAST; k++) begin
      dec[k] = v1_q & (&p_q[k+1 +: RUN]) & ~p_q[k+RUN+1];
    end
    hit_d = cfg_q.first_hit ? (dec & (~dec + SLICES'(1))) : dec;
  end

  always_comb begin
    match_d = '0;
    for (int c = 0; c < NCLASS; c++) begin
      match_d[c] = (|(hit_q[WB-1:0] & win_q[c])) & cfg_q.en[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q   <= '0;
      match_q <= '0;
    end else begin
      hit_q   <= hit_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q.en        <= 8'hFF;
      cfg_q.first_hit <= 1'b0;
      for (int c = 0; c < NCLASS; c++) begin
        win_q[c] <= WIN_INIT[32*c +: WB];
      end
    end else if (bus.Write) begin
      if (off == 8'd0) begin
        cfg_q.en        <= bus.DataIn[7:0];
        cfg_q.first_hit <= bus.DataIn[9];
      end
      for (int c = 0; c < NCLASS; c++) begin
        if (off == 8'(c + 1)) win_q[c] <= bus.DataIn[WB-1:0];
      end
    end
  end

  // Counter clear takes priority over an increment on the same edge.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCLASS; c++) begin
      if (!rst || clr) begin
        cnt_q[c] <= '0;
      end else if (match_q[c] && (cnt_q[c] != 16'hFFFF)) begin
        cnt_q[c] <= cnt_q[c] + 16'd1;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    if (bus.Read) begin
      if (off == 8'd0) begin
        rd_dat[7:0] = cfg_q.en;
        rd_dat[9]   = cfg_q.first_hit;
      end
      for (int c = 0; c < NCLASS; c++) begin
        if (off == 8'(c + 1))          rd_dat[WB-1:0] = win_q[c];
        if (off == 8'(NCLASS + 1 + c)) rd_dat[15:0]   = cnt_q[c];
      end
    end
  end

  assign bus.DataOut = rd_dat;
  assign bus.Hit     = hit_q;
  assign bus.Match   = match_q;
endmodule

// File: tb/tb_fine_time_pid_multi.sv
// Directed stimulus with a cycle-tagged scoreboard for Hit, Match and local-bus reads.
module tb_fine_time_pid_multi;
  localparam int               SLICES   = 32;
  localparam int               NCLASS   = 3;
  localparam logic [7:0]       BASE     = 8'h40;
  localparam logic [95:0]      WIN_INIT = {32'h0, 32'h0000_1000, 32'h0000_0001};

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic fin = 1'b0;
  chk_t hq[$];
  chk_t mq[$];
  chk_t rq[$];
  chk_t e;

  fine_time_pid_multi_if #(.SLICES(SLICES), .NCLASS(NCLASS)) bus ();

  fine_time_pid_multi #(
    .SLICES(SLICES), .NCLASS(NCLASS), .RUN(3), .BASE(BASE), .WIN_INIT(WIN_INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d expired before end of test", cyc);
    $fatal(1);
  end

  // Monitor: pop expectations that fall due this cycle; any other nonzero output is unexpected.
  always @(negedge clk) begin
    if (hq.size() > 0 && hq[0].cyc == cyc) begin
      e = hq.pop_front();
      total++;
      if (bus.Hit !== e.val) begin
        bad++;
        $display("FAIL hit cyc=%0d got=%h want=%h", cyc, bus.Hit, e.val);
      end
    end else if (bus.Hit !== '0) begin
      total++; bad++;
      $display("FAIL hit_unexpected cyc=%0d got=%h want=0", cyc, bus.Hit);
    end

    if (mq.size() > 0 && mq[0].cyc == cyc) begin
      e = mq.pop_front();
      total++;
      if (bus.Match !== e.val[2:0]) begin
        bad++;
        $display("FAIL match cyc=%0d got=%b want=%b", cyc, bus.Match, e.val[2:0]);
      end
    end else if (bus.Match !== '0) begin
      total++; bad++;
      $display("FAIL match_unexpected cyc=%0d got=%b want=000", cyc, bus.Match);
    end

    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      e = rq.pop_front();
      total++;
      if (bus.DataOut !== e.val) begin
        bad++;
        $display("FAIL read addr=%h cyc=%0d got=%h want=%h", bus.Address, cyc, bus.DataOut, e.val);
      end
    end else if (!bus.Read && bus.DataOut !== 32'h0) begin
      total++; bad++;
      $display("FAIL dataout_idle cyc=%0d got=%h want=0", cyc, bus.DataOut);
    end

    if (fin) begin
      total++;
      if (hq.size() + mq.size() + rq.size() != 0) begin
        bad++;
        $display("FAIL leftover got=%0d want=0 pending expectations", hq.size() + mq.size() + rq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.TimeVld = 1'b0;
    bus.TimeIn  = '0;
    repeat (n) tick();
  endtask

  task automatic sample(input logic [31:0] pat, input logic vld,
                        input logic [31:0] eh, input logic [2:0] em);
    bus.TimeIn  = pat;
    bus.TimeVld = vld;
    hq.push_back('{cyc + 2, eh});
    mq.push_back('{cyc + 3, {29'd0, em}});
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.Address = a;
    bus.DataIn  = d;
    bus.Write   = 1'b1;
    tick();
    bus.Write   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    bus.Address = a;
    bus.Read    = 1'b1;
    rq.push_back('{cyc, exp});
    tick();
    bus.Read    = 1'b0;
  endtask

  task automatic rd_idle(input logic [7:0] a);
    bus.Address = a;
    bus.Read    = 1'b0;
    rq.push_back('{cyc, 32'h0});
    tick();
  endtask

  initial begin
    bus.TimeIn = '0; bus.TimeVld = 1'b0; bus.DataIn = '0;
    bus.Address = '0; bus.Read = 1'b0; bus.Write = 1'b0;

    // Reset state
    rst = 1'b0;
    tick(); tick();
    hq.push_back('{cyc, 32'h0});
    mq.push_back('{cyc, 32'h0});
    rst = 1'b1;
    rd(BASE + 8'd0, 32'h0000_00FF);
    rd(BASE + 8'd4, 32'h0);
    rd(BASE + 8'd1, 32'h1);
    rd(BASE + 8'd7, 32'h0);
    rd_idle(BASE);

    // Single leading edge at k=0
    wr(BASE + 8'd1, 32'h1);
    sample(32'h0000_000E, 1'b1, 32'h1, 3'b001);
    idle(4);
    rd(BASE + 8'd4, 32'h1);

    // Multiple edges (k=0,4,12), then first-hit mode
    sample(32'h0000_F0EE, 1'b1, 32'h0000_1011, 3'b011);
    idle(4);
    wr(BASE + 8'd0, 32'h0000_02FF);
    rd(BASE + 8'd0, 32'h0000_02FF);
    sample(32'h0000_F0EE, 1'b1, 32'h0000_0001, 3'b001);
    idle(4);

    // Class enables; window 2 catches the k=4 edge
    wr(BASE + 8'd3, 32'h10);
    wr(BASE + 8'd0, 32'h0000_0001);
    sample(32'h0000_F0EE, 1'b1, 32'h0000_1011, 3'b001);
    idle(4);
    wr(BASE + 8'd0, 32'h0000_00FF);
    sample(32'h0000_F0EE, 1'b1, 32'h0000_1011, 3'b111);
    idle(4);
    rd(BASE + 8'd0, 32'h0000_00FF);
    rd(BASE + 8'd4, 32'd5);
    rd(BASE + 8'd5, 32'd2);
    rd(BASE + 8'd6, 32'd1);
    rd(BASE + 8'd2, 32'h0000_1000);
    rd(BASE + 8'd3, 32'h0000_0010);
    wr(BASE + 8'd4, 32'h1234);
    rd(BASE + 8'd4, 32'd5);

    // Saturation over a back-to-back stream
    for (int i = 0; i < 65540; i++) sample(32'h0000_000E, 1'b1, 32'h1, 3'b001);
    idle(5);
    rd(BASE + 8'd4, 32'h0000_FFFF);
    rd(BASE + 8'd5, 32'd2);
    rd(BASE + 8'd6, 32'd1);

    // Counter clear coincident with a Match[0] pulse
    sample(32'h0000_000E, 1'b1, 32'h1, 3'b001);
    idle(2);
    wr(BASE + 8'd0, 32'h0000_0101);
    rd(BASE + 8'd4, 32'h0);
    rd(BASE + 8'd5, 32'h0);
    rd(BASE + 8'd0, 32'h0000_0001);
    wr(BASE + 8'd0, 32'h0000_00FF);

    // Reset one clock after a valid sample discards it
    sample(32'h0000_000E, 1'b1, 32'h0, 3'b000);
    bus.TimeVld = 1'b0;
    bus.TimeIn  = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle(4);
    rd(BASE + 8'd0, 32'h0000_00FF);
    rd(BASE + 8'd3, 32'h0);

    // Valid pattern without TimeVld
    sample(32'h0000_000E, 1'b0, 32'h0, 3'b000);
    idle(4);
    rd(BASE + 8'd4, 32'h0);

    fin = 1'b1;
    repeat (3) tick();
  end
endmodule
